// File: rtl/pointwise_stream_mac.sv
// Pointwise (1x1) convolution over a serialized per-pixel channel stream.
// Computes NUM_FILTERS signed fixed-point dot products in parallel, one packed word per pixel.
module pointwise_stream_mac #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAC_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned NUM_FILTERS  = 2,
    parameter int unsigned ACC_WIDTH    = 40
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        w_wr_en,
    input  logic [$clog2(NUM_FILTERS*NUM_CHANNELS)-1:0] w_wr_addr,
    input  logic [DATA_WIDTH-1:0]                       w_wr_data,
    output logic                                        w_wr_ready,
    output logic [NUM_FILTERS*DATA_WIDTH-1:0]           out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready
);

    localparam int unsigned NUM_WEIGHTS = NUM_FILTERS * NUM_CHANNELS;
    localparam int unsigned AW          = $clog2(NUM_WEIGHTS);
    localparam int unsigned CW          = $clog2(NUM_CHANNELS);
    localparam int unsigned PW          = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] ROUND   = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic [CW-1:0]                       ch_idx_q, ch_idx_d;
    logic                                group_active_q, group_active_d;
    logic                                out_valid_q, out_valid_d;
    logic [NUM_FILTERS*DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic signed [DATA_WIDTH-1:0]        w_q [NUM_FILTERS][NUM_CHANNELS];
    logic signed [ACC_WIDTH-1:0]         acc_q [NUM_FILTERS];

    logic                                last_ch;
    logic                                beat;
    logic                                w_wr_fire;
    logic signed [PW-1:0]                prod [NUM_FILTERS];
    logic signed [ACC_WIDTH-1:0]         sum [NUM_FILTERS];
    logic signed [ACC_WIDTH:0]           rnd [NUM_FILTERS];
    logic signed [ACC_WIDTH:0]           shifted [NUM_FILTERS];
    logic [NUM_FILTERS*DATA_WIDTH-1:0]   result;

    // The accumulators are decoupled from the output register, so only the
    // finalizing beat has to wait for the output slot to free up.
    always_comb begin
        last_ch    = (ch_idx_q == CW'(NUM_CHANNELS - 1));
        in_ready   = !last_ch || !out_valid_q || out_ready;
        beat       = in_valid && in_ready;
        w_wr_ready = !group_active_q;
        w_wr_fire  = w_wr_en && !group_active_q && (32'(w_wr_addr) < NUM_WEIGHTS);
    end

    always_comb begin
        result = '0;
        for (int f = 0; f < int'(NUM_FILTERS); f++) begin
            prod[f]    = $signed(in_data) * w_q[f][ch_idx_q];
            sum[f]     = ((ch_idx_q == '0) ? '0 : acc_q[f])
                         + {{(ACC_WIDTH - PW){prod[f][PW-1]}}, prod[f]};
            rnd[f]     = {sum[f][ACC_WIDTH-1], sum[f]} + ROUND;
            shifted[f] = rnd[f] >>> FRAC_BITS;
            if (shifted[f] > SAT_MAX) begin
                result[f*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            end else if (shifted[f] < SAT_MIN) begin
                result[f*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
            end else begin
                result[f*DATA_WIDTH +: DATA_WIDTH] = shifted[f][DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ch_idx_d       = ch_idx_q;
        group_active_d = group_active_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        if (beat) begin
            ch_idx_d       = last_ch ? '0 : ch_idx_q + CW'(1);
            group_active_d = !last_ch;
        end
        // Finalize wins over retirement so back-to-back words leave no bubble.
        if (beat && last_ch) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx_q       <= '0;
            group_active_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            for (int f = 0; f < int'(NUM_FILTERS); f++) begin
                acc_q[f] <= '0;
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    w_q[f][c] <= '0;
                end
            end
        end else begin
            ch_idx_q       <= ch_idx_d;
            group_active_q <= group_active_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            for (int f = 0; f < int'(NUM_FILTERS); f++) begin
                if (beat) begin
                    acc_q[f] <= sum[f];
                end
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    if (w_wr_fire && (w_wr_addr == AW'(f * int'(NUM_CHANNELS) + c))) begin
                        w_q[f][c] <= w_wr_data;
                    end
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pointwise_stream_mac.sv
// Directed bench for pointwise_stream_mac: Q8.8, 4 channels, 2 filters.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_pointwise_stream_mac;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        w_wr_en;
    logic [2:0]  w_wr_addr;
    logic [15:0] w_wr_data;
    logic        w_wr_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int fails  = 0;

    pointwise_stream_mac dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .w_wr_en    (w_wr_en),
        .w_wr_addr  (w_wr_addr),
        .w_wr_data  (w_wr_data),
        .w_wr_ready (w_wr_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic write_w(input int addr, input logic [15:0] data);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = 3'(addr);
        w_wr_data = data;
        @(posedge clk);
        #1 w_wr_en = 1'b0;
    endtask

    task automatic load_filter(input int f, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3);
        write_w(f * 4 + 0, d0);
        write_w(f * 4 + 1, d1);
        write_w(f * 4 + 2, d2);
        write_w(f * 4 + 3, d3);
    endtask

    task automatic send_beat(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3);
        send_beat(d0);
        send_beat(d1);
        send_beat(d2);
        send_beat(d3);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; in_data = '0; in_valid = 1'b0; w_wr_en = 1'b0;
        w_wr_addr = '0; w_wr_data = '0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h required 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (w_wr_ready !== 1'b1) begin fails++; $display("FAIL reset_w_wr_ready: got %b required 1", w_wr_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        load_filter(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        load_filter(1, 16'h0080, 16'h0080, 16'h0080, 16'h0080);
        send_beat(16'h0100);
        send_beat(16'h0200);
        send_beat(16'h0300);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
        send_beat(16'h0400);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b required 1", out_valid); end
        checks++; if (out_data[15:0] !== 16'h0A00) begin fails++; $display("FAIL basic_f0: got %h required 0a00", out_data[15:0]); end
        checks++; if (out_data[31:16] !== 16'h0500) begin fails++; $display("FAIL basic_f1: got %h required 0500", out_data[31:16]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_retire: got %b required 0", out_valid); end
    endtask

    task automatic test_saturation;
        load_filter(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        load_filter(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send_group(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        checks++; if (out_data !== 32'h7FFF_7FFF) begin fails++; $display("FAIL sat_pos: got %h required 7fff7fff", out_data); end
        send_group(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        checks++; if (out_data !== 32'h8000_8000) begin fails++; $display("FAIL sat_neg: got %h required 80008000", out_data); end
    endtask

    task automatic test_rounding;
        // Filter 1 keeps 0x7FFF weights: 1*0x7FFF = 32767, +128 >> 8 = 0x0080.
        load_filter(0, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
        send_group(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (out_data[15:0] !== 16'h0001) begin fails++; $display("FAIL round_half_up: got %h required 0001", out_data[15:0]); end
        checks++; if (out_data[31:16] !== 16'h0080) begin fails++; $display("FAIL round_f1: got %h required 0080", out_data[31:16]); end
        write_w(0, 16'h0040);
        send_group(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (out_data[15:0] !== 16'h0000) begin fails++; $display("FAIL round_down: got %h required 0000", out_data[15:0]); end
        // -1 * 0xC0 = -192, +128 = -64, >>> 8 = -1; filter1: -32767+128 >>> 8 = -128.
        write_w(0, 16'h00C0);
        send_group(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (out_data !== 32'hFF80_FFFF) begin fails++; $display("FAIL round_negative: got %h required ff80ffff", out_data); end
    endtask

    task automatic test_weight_gating;
        load_filter(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        load_filter(1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        send_beat(16'h0100);
        @(negedge clk);
        w_wr_en = 1'b1; w_wr_addr = 3'd1; w_wr_data = 16'h0200;
        checks++; if (w_wr_ready !== 1'b0) begin fails++; $display("FAIL gate_ready_mid: got %b required 0", w_wr_ready); end
        @(posedge clk);
        #1 w_wr_en = 1'b0;
        send_beat(16'h0100);
        send_beat(16'h0100);
        send_beat(16'h0100);
        @(negedge clk);
        checks++; if (out_data !== 32'h0400_0400) begin fails++; $display("FAIL gate_dropped: got %h required 04000400", out_data); end
        checks++; if (w_wr_ready !== 1'b1) begin fails++; $display("FAIL gate_ready_idle: got %b required 1", w_wr_ready); end
        write_w(1, 16'h0200);
        send_group(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        checks++; if (out_data !== 32'h0400_0500) begin fails++; $display("FAIL gate_applied: got %h required 04000500", out_data); end
        // Weight write coinciding with a channel-0 beat: that beat sees the old weight.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0100;
        w_wr_en = 1'b1; w_wr_addr = 3'd0; w_wr_data = 16'h0300;
        @(posedge clk);
        #1 begin in_valid = 1'b0; w_wr_en = 1'b0; end
        send_beat(16'h0000);
        send_beat(16'h0000);
        send_beat(16'h0000);
        @(negedge clk);
        checks++; if (out_data[15:0] !== 16'h0100) begin fails++; $display("FAIL gate_same_cycle_old: got %h required 0100", out_data[15:0]); end
        send_group(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (out_data[15:0] !== 16'h0300) begin fails++; $display("FAIL gate_same_cycle_new: got %h required 0300", out_data[15:0]); end
    endtask

    task automatic test_backpressure;
        load_filter(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        load_filter(1, 16'h0080, 16'h0080, 16'h0080, 16'h0080);
        out_ready = 1'b0;
        send_group(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        checks++; if (out_data !== 32'h0200_0400 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_first: got %h/%b required 02000400/1", out_data, out_valid); end
        in_valid = 1'b1; in_data = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept_ch%0d: got %b required 1", i, in_ready); end
            @(negedge clk);
        end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ch3: got %b required 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_hold: got %b required 0", in_ready); end
        checks++; if (out_data !== 32'h0200_0400 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold: got %h/%b required 02000400/1", out_data, out_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 begin out_ready = 1'b0; in_valid = 1'b0; end
        checks++; if (out_data !== 32'h0400_0800 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_second: got %h/%b required 04000800/1", out_data, out_valid); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_group(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        send_beat(16'h0100);
        send_beat(16'h0100);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || w_wr_ready !== 1'b0) begin fails++; $display("FAIL rstmid_pre: got valid=%b wr_ready=%b required 1/0", out_valid, w_wr_ready); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL rstmid_data: got %h required 00000000", out_data); end
        checks++; if (w_wr_ready !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got wr=%b in=%b required 1/1", w_wr_ready, in_ready); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        send_group(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin fails++; $display("FAIL rstmid_zero_w: got %h/%b required 00000000/1", out_data, out_valid); end
        load_filter(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        send_group(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0A00) begin fails++; $display("FAIL rstmid_reload: got %h/%b required 00000a00/1", out_data, out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_weight_gating();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pointwise_stream_mac.md
Name: pointwise_stream_mac

Overview:
- Consumes the serialized per-pixel channel stream (channel 0..NUM_CHANNELS-1, one word per beat) produced by the channel interleaving stage.
- Performs a 1x1 (pointwise) convolution for NUM_FILTERS output filters in parallel, in signed fixed point.
- Emits one packed word per pixel carrying all filter results.
- Sits between the interleaver and the activation/requantization stage of the MobileNet pointwise layer.

Parameters:
- DATA_WIDTH, 16: signed fixed-point width of data, weights and outputs (two's complement).
- FRAC_BITS, 8: fractional bits of data, weights and outputs (default Q8.8).
- NUM_CHANNELS, 4: input channels per pixel group; must be >= 2.
- NUM_FILTERS, 2: output filters computed in parallel.
- ACC_WIDTH, 40: signed accumulator width; must be >= 2*DATA_WIDTH + clog2(NUM_CHANNELS).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  serialized channel sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- w_wr_en  in  1  weight write strobe
- w_wr_addr  in  clog2(NUM_FILTERS*NUM_CHANNELS)  weight index = filter*NUM_CHANNELS + channel
- w_wr_data  in  DATA_WIDTH  weight value
- w_wr_ready  out  1  weight writes accepted this cycle
- out_data  out  NUM_FILTERS*DATA_WIDTH  filter f result at bits [f*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset (async, rst=1), all values zero:
  - outputs: out_data, out_valid.
  - internal: weight registers, accumulators, channel counter ch_idx, group_active.
  - Deassertion is sampled on clk. After reset, in_ready=1 and w_wr_ready=1.
- Input beat = in_valid & in_ready.
  - The beat is tagged with channel ch_idx.
  - ch_idx increments per beat and wraps NUM_CHANNELS-1 -> 0.
  - group_active=1 after a beat on channels 0..NUM_CHANNELS-2; cleared by the last-channel beat.
- Accumulate, for every filter f on each beat:
  - acc[f] <= (ch_idx==0 ? 0 : acc[f]) + sext(in_data * w[f][ch_idx]).
  - Product is full 2*DATA_WIDTH signed; no intermediate rounding.
- Finalize on the beat with ch_idx==NUM_CHANNELS-1:
  - sum = acc[f] + product of that beat.
  - r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift (round half up).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Result is registered into out_data; out_valid=1 the next cycle. Latency: last-channel beat at cycle T -> out_valid at T+1.
- in_ready:
  - 1 when ch_idx != NUM_CHANNELS-1: the accumulators are independent of the output register, so the next group's channels flow while the output is held.
  - 1 when ch_idx == NUM_CHANNELS-1 only if (!out_valid || out_ready).
  - Never combinationally depends on in_valid.
- Output handshake:
  - out_valid & out_ready retires the word. out_valid drops the next cycle unless a new finalize occurs in the same cycle.
  - A new finalize in the same cycle as retirement loads the new word with out_valid kept at 1 (back-to-back, no bubble).
  - While out_valid & !out_ready, out_data and out_valid are held stable.
- Weights:
  - w_wr_ready = !group_active.
  - Write occurs when w_wr_en & w_wr_ready. The new weight is used from the next beat onward.
  - A write while group_active=1 is dropped; no partial-group weight mixing.
  - A write and a channel-0 beat in the same cycle: the beat uses the old weight.
  - Addresses >= NUM_FILTERS*NUM_CHANNELS are ignored.
- Reset mid-group discards the partial accumulation and any held output. The first beat after reset is channel 0.
- Throughput: one channel per cycle; one pixel result per NUM_CHANNELS cycles at full rate.

Test Plan:
- Basic result:
  - Stimulus: w[0][*]=0x0100 (1.0), w[1][*]=0x0080 (0.5); stream 0x0100,0x0200,0x0300,0x0400 with out_ready=1.
  - Required: one cycle after the 4th beat, out_valid=1, filter0=0x0A00, filter1=0x0500.
- Saturation:
  - Stimulus: all weights 0x7FFF, inputs 0x7FFF x4.
  - Required: both filters 0x7FFF.
  - Stimulus: inputs 0x8000 with weights 0x7FFF.
  - Required: both filters 0x8000.
- Rounding:
  - Stimulus: w[0][0]=0x0080, other filter-0 weights 0; inputs 0x0001,0,0,0.
  - Required: filter0=0x0001 (128+128>>8).
  - Stimulus: same with w[0][0]=0x0040.
  - Required: filter0=0x0000.
- Backpressure:
  - Stimulus: hold out_ready=0 after the first result; stream a second group continuously.
  - Required: channels 0-2 accepted, in_ready=0 at channel 3, out_data stable.
  - Stimulus: raise out_ready for 1 cycle.
  - Required: first word retires, channel 3 accepted that cycle, second word valid next cycle with no bubble.
- Weight write gating:
  - Stimulus: write w[0][1]=0x0200 after the channel-0 beat.
  - Required: w_wr_ready=0 and the write is dropped; the result uses the old weight.
  - Stimulus: the same write between groups.
  - Required: the write takes effect and the next result reflects 2.0x on channel 1.
- Reset mid-group:
  - Stimulus: assert rst after 2 beats with out_valid=1 pending.
  - Required: out_valid=0 immediately (async) and weights=0; after release, the next 4 beats form a fresh group with result 0 until weights are reloaded.
